// File: rtl/swipt_bpsk_tx.sv
`default_nettype none
// ============================================================================
// Module   : swipt_bpsk_tx
// Purpose  : BPSK transmitter for a SWIPT link. A phase accumulator (NCO)
//            sets the carrier. Bytes are framed as SYNC, then an alternating
//            preamble, then 8 data symbols MSB first. The modulated carrier
//            drives two complementary gate outputs with dead time inserted
//            around every edge.
// Ports    : clk, nrst        - clock, asynchronous active-low reset
//            swiptAlive       - link enable; low aborts and freezes the NCO
//            load_freq, freq  - load a new phase step (MSB forced to 0)
//            tx_data/valid/ready - byte handshake
//            phase            - accumulator value
//            gate_p, gate_n   - registered complementary drive
//            busy, bit_strobe, frame_done - status pulses/levels
// Revision : 1.0 - initial release
// ============================================================================
module swipt_bpsk_tx #(
  parameter int                    PHASE_BITS         = 32,
  parameter logic [PHASE_BITS-1:0] INITIAL_PHASE_STEP = PHASE_BITS'(32'h1000_0000),
  parameter int                    CYCLES_PER_BIT     = 4,
  parameter int                    PREAMBLE_LEN       = 4,
  parameter int                    DEAD_CYCLES        = 1
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  swiptAlive,
  input  logic                  load_freq,
  input  logic [PHASE_BITS-2:0] freq,
  input  logic [7:0]            tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [PHASE_BITS-1:0] phase,
  output logic                  gate_p,
  output logic                  gate_n,
  output logic                  busy,
  output logic                  bit_strobe,
  output logic                  frame_done
);

  localparam logic [7:0] CYC_LAST  = 8'(CYCLES_PER_BIT - 1);
  localparam logic [3:0] PRE_LAST  = 4'(PREAMBLE_LEN - 1);
  localparam logic [3:0] DATA_LAST = 4'd7;
  localparam logic [3:0] DEAD_INIT = 4'(DEAD_CYCLES);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SYNC     = 2'd1,
    PREAMBLE = 2'd2,
    DATA     = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // NCO
  // --------------------------------------------------------------------------
  logic [PHASE_BITS-1:0] acc;
  logic [PHASE_BITS-1:0] step;
  logic [PHASE_BITS:0]   sum;
  logic                  wrap;

  assign sum   = {1'b0, acc} + {1'b0, step};
  // The carry is only meaningful when the addition actually takes place.
  assign wrap  = swiptAlive & sum[PHASE_BITS];
  assign phase = acc;

  // A step loaded in the same clock as a wrap only lands at the edge, so the
  // wrap in progress naturally uses the old step.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      acc  <= '0;
      step <= INITIAL_PHASE_STEP;
    end else begin
      if (swiptAlive) acc <= sum[PHASE_BITS-1:0];
      if (load_freq)  step <= {1'b0, freq};
    end
  end

  // --------------------------------------------------------------------------
  // Framing FSM
  // --------------------------------------------------------------------------
  state_t     state, state_nx;
  logic [7:0] shift, shift_nx;
  logic [7:0] hold, hold_nx;
  logic       hold_valid, hold_valid_nx;
  logic [7:0] cyc_cnt, cyc_nx;
  logic [3:0] sym_cnt, sym_cnt_nx;
  logic       sym, sym_nx;
  logic       strobe_nx, done_nx;
  logic       ready_en;
  logic       accept;
  logic       sym_end;
  logic [7:0] next_byte;

  // ready_en keeps tx_ready low until the first clock after reset release.
  assign tx_ready = ready_en & swiptAlive &
                    ((state == IDLE) ||
                     ((state == DATA) && (sym_cnt == DATA_LAST) && !hold_valid));
  assign accept    = tx_valid & tx_ready;
  assign sym_end   = wrap && (cyc_cnt == CYC_LAST);
  // A byte accepted on the very clock of the final wrap bypasses the holding
  // register and is loaded straight into the shift register.
  assign next_byte = hold_valid ? hold : tx_data;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= IDLE;
      shift      <= '0;
      hold       <= '0;
      hold_valid <= 1'b0;
      cyc_cnt    <= '0;
      sym_cnt    <= '0;
      sym        <= 1'b0;
      bit_strobe <= 1'b0;
      frame_done <= 1'b0;
      ready_en   <= 1'b0;
    end else begin
      state      <= state_nx;
      shift      <= shift_nx;
      hold       <= hold_nx;
      hold_valid <= hold_valid_nx;
      cyc_cnt    <= cyc_nx;
      sym_cnt    <= sym_cnt_nx;
      sym        <= sym_nx;
      bit_strobe <= strobe_nx;
      frame_done <= done_nx;
      ready_en   <= swiptAlive;
    end
  end

  always_comb begin
    state_nx      = state;
    shift_nx      = shift;
    hold_nx       = hold;
    hold_valid_nx = hold_valid;
    cyc_nx        = cyc_cnt;
    sym_cnt_nx    = sym_cnt;
    sym_nx        = sym;
    strobe_nx     = 1'b0;
    done_nx       = 1'b0;

    if (!swiptAlive) begin
      state_nx      = IDLE;
      shift_nx      = '0;
      hold_nx       = '0;
      hold_valid_nx = 1'b0;
      cyc_nx        = '0;
      sym_cnt_nx    = '0;
      sym_nx        = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            shift_nx   = tx_data;
            state_nx   = SYNC;
            cyc_nx     = '0;
            sym_cnt_nx = '0;
            sym_nx     = 1'b0;
          end
        end

        SYNC: begin
          if (wrap) begin
            state_nx   = PREAMBLE;
            cyc_nx     = '0;
            sym_cnt_nx = '0;
            sym_nx     = 1'b1;
            strobe_nx  = 1'b1;
          end
        end

        PREAMBLE: begin
          if (sym_end) begin
            cyc_nx    = '0;
            strobe_nx = 1'b1;
            if (sym_cnt == PRE_LAST) begin
              state_nx   = DATA;
              sym_cnt_nx = '0;
              sym_nx     = shift[7];
            end else begin
              sym_cnt_nx = sym_cnt + 4'd1;
              sym_nx     = ~sym;
            end
          end else if (wrap) begin
            cyc_nx = cyc_cnt + 8'd1;
          end
        end

        DATA: begin
          if (accept) begin
            hold_nx       = tx_data;
            hold_valid_nx = 1'b1;
          end
          if (sym_end) begin
            cyc_nx = '0;
            if (sym_cnt == DATA_LAST) begin
              sym_cnt_nx    = '0;
              hold_valid_nx = 1'b0;
              if (hold_valid || accept) begin
                shift_nx  = next_byte;
                sym_nx    = next_byte[7];
                strobe_nx = 1'b1;
              end else begin
                state_nx = IDLE;
                sym_nx   = 1'b0;
                done_nx  = 1'b1;
              end
            end else begin
              shift_nx   = {shift[6:0], 1'b0};
              sym_nx     = shift[6];
              sym_cnt_nx = sym_cnt + 4'd1;
              strobe_nx  = 1'b1;
            end
          end else if (wrap) begin
            cyc_nx = cyc_cnt + 8'd1;
          end
        end

        default: state_nx = IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Gate driver with dead time
  // --------------------------------------------------------------------------
  logic       raw, raw_q, toggle;
  logic [3:0] dead_cnt, dead_nx;

  assign raw     = acc[PHASE_BITS-1] ^ sym;
  assign toggle  = raw ^ raw_q;
  assign dead_nx = toggle ? DEAD_INIT :
                   ((dead_cnt != 4'd0) ? (dead_cnt - 4'd1) : 4'd0);

  // Gates are driven from the counter value being loaded, so the edge that
  // loads dead time already blanks both outputs.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      raw_q    <= 1'b0;
      dead_cnt <= '0;
      gate_p   <= 1'b0;
      gate_n   <= 1'b0;
    end else if (!swiptAlive) begin
      raw_q    <= raw;
      dead_cnt <= '0;
      gate_p   <= 1'b0;
      gate_n   <= 1'b0;
    end else begin
      raw_q    <= raw;
      dead_cnt <= dead_nx;
      gate_p   <= (dead_nx == 4'd0) &  raw;
      gate_n   <= (dead_nx == 4'd0) & ~raw;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_swipt_bpsk_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_swipt_bpsk_tx
// Purpose  : Self-checking bench for swipt_bpsk_tx: reset values, the free
//            running carrier, framed bytes (single and back-to-back), link
//            abort, step reload on a wrap, and asynchronous reset mid-frame.
// Revision : 1.0 - initial release
// ============================================================================
module tb_swipt_bpsk_tx;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        swiptAlive = 1'b1;
  logic        load_freq = 1'b0;
  logic [30:0] freq = '0;
  logic [7:0]  tx_data = '0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [31:0] phase;
  logic        gate_p, gate_n, busy, bit_strobe, frame_done;

  swipt_bpsk_tx dut (
    .clk        (clk),
    .nrst       (nrst),
    .swiptAlive (swiptAlive),
    .load_freq  (load_freq),
    .freq       (freq),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .phase      (phase),
    .gate_p     (gate_p),
    .gate_n     (gate_n),
    .busy       (busy),
    .bit_strobe (bit_strobe),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit exp_q[$];

  typedef struct {
    int          k;
    logic [31:0] ph;
    logic        gp;
    logic        gn;
  } vec_t;
  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) exp_q.push_back(b[i]);
  endtask

  task automatic wait_strobes(input int n, input string tag);
    int seen = 0;
    int c = 0;
    while (seen < n && c < 3000) begin
      @(negedge clk);
      c++;
      if (bit_strobe) seen++;
    end
    if (seen < n) begin
      checks++;
      errors++;
      $display("FAIL %s: saw %0d strobes, required %0d", tag, seen, n);
    end
  endtask

  // Sends b0 (and b1 back-to-back when two=1) and scores every symbol.
  // Called and returns at a negedge.
  task automatic run_frames(input logic [7:0] b0, input bit two,
                            input logic [7:0] b1, input int sym_len);
    int  nstr = 0;
    int  t0 = 0;
    int  last = 0;
    int  cd = 0;
    bit  done = 0;
    bit  drop_valid = 0;
    bit  e;
    int  nsym;
    nsym = two ? 20 : 12;
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back((i % 2) == 0);
    push_byte(b0);
    check("ready_idle", tx_ready, 1);
    tx_data  = b0;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check("busy_sync", busy, 1);
    for (int c = 0; c < 4000 && !done; c++) begin
      @(negedge clk);
      if (drop_valid) begin
        tx_valid   = 1'b0;
        drop_valid = 0;
      end
      if (bit_strobe) begin
        nstr++;
        if (nstr == 1) t0 = cyc;
        else check("sym_len", cyc - last, sym_len);
        last = cyc;
        cd   = 5;
        if (two && nstr == 12) begin
          check("ready_last", tx_ready, 1);
          tx_data    = b1;
          tx_valid   = 1'b1;
          drop_valid = 1;
          push_byte(b1);
        end
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          // Carrier MSB is 0 here, so the unmodulated gate_p would be 0.
          if (exp_q.size() == 0) check("sym_extra", 1, 0);
          else begin
            e = exp_q.pop_front();
            check("sym_p", gate_p, e);
            check("sym_n", gate_n, !e);
          end
        end
      end
      if (frame_done) begin
        done = 1;
        check("frame_len", cyc - t0, nsym * sym_len);
        check("strobes", nstr, nsym);
        check("queue_empty", exp_q.size(), 0);
        check("busy_done", busy, 0);
        check("ready_done", tx_ready, 1);
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout: no frame_done, strobes %0d required %0d", nstr, nsym);
    end
  endtask

  initial begin
    int cnt;
    logic [31:0] ph;
    vecs[0]  = '{1,  32'h1000_0000, 1'b0, 1'b1};
    vecs[1]  = '{8,  32'h8000_0000, 1'b0, 1'b1};
    vecs[2]  = '{9,  32'h9000_0000, 1'b0, 1'b0};
    vecs[3]  = '{10, 32'hA000_0000, 1'b1, 1'b0};
    vecs[4]  = '{16, 32'h0000_0000, 1'b1, 1'b0};
    vecs[5]  = '{17, 32'h1000_0000, 1'b0, 1'b0};
    vecs[6]  = '{18, 32'h2000_0000, 1'b0, 1'b1};
    vecs[7]  = '{24, 32'h8000_0000, 1'b0, 1'b1};
    vecs[8]  = '{25, 32'h9000_0000, 1'b0, 1'b0};
    vecs[9]  = '{26, 32'hA000_0000, 1'b1, 1'b0};
    vecs[10] = '{32, 32'h0000_0000, 1'b1, 1'b0};
    vecs[11] = '{33, 32'h1000_0000, 1'b0, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_phase", phase, 0);
    check("rst_gates", {gate_p, gate_n}, 0);
    check("rst_busy", busy, 0);
    check("rst_strobe", {bit_strobe, frame_done}, 0);
    check("rst_ready", tx_ready, 0);
    nrst = 1'b1;

    // Free-running carrier, no data
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      if (k == 1) check("ready_after_rst", tx_ready, 1);
      foreach (vecs[i]) begin
        if (vecs[i].k == k) begin
          check($sformatf("nco_phase_k%0d", k), phase, vecs[i].ph);
          check($sformatf("nco_gates_k%0d", k), {gate_p, gate_n}, {vecs[i].gp, vecs[i].gn});
        end
      end
    end

    // Single byte, then back-to-back bytes
    run_frames(8'hA5, 0, 8'h00, 64);
    run_frames(8'hA5, 1, 8'h3C, 64);

    // Link abort mid-preamble
    tx_data  = 8'h81;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    wait_strobes(2, "abort_wait");
    ph = phase;
    swiptAlive = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_gates", {gate_p, gate_n}, 0);
    check("abort_ready", tx_ready, 0);
    check("abort_phase", phase, ph);
    repeat (3) @(negedge clk);
    check("abort_frozen", phase, ph);
    swiptAlive = 1'b1;
    repeat (2) @(negedge clk);
    check("reenable_ready", tx_ready, 1);
    check("reenable_busy", busy, 0);
    cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (bit_strobe || busy) cnt++;
    end
    check("no_resume", cnt, 0);

    // Handshake coinciding with the link dropping is ignored
    swiptAlive = 1'b0;
    tx_data    = 8'hFF;
    tx_valid   = 1'b1;
    @(negedge clk);
    check("drop_hs_busy", busy, 0);
    tx_valid   = 1'b0;
    swiptAlive = 1'b1;
    repeat (2) @(negedge clk);
    check("drop_hs_idle", busy, 0);

    // Step reload on a wrap clock
    cnt = 0;
    while (phase != 32'hF000_0000 && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    check("find_wrap", phase, 32'hF000_0000);
    load_freq = 1'b1;
    freq      = 31'h0800_0000;
    @(negedge clk);
    load_freq = 1'b0;
    check("wrap_old_step", phase, 32'h0000_0000);
    @(negedge clk);
    check("new_step", phase, 32'h0800_0000);
    repeat (32) @(negedge clk);
    check("period32", phase, 32'h0800_0000);
    run_frames(8'h5A, 0, 8'h00, 128);

    // Asynchronous reset mid-DATA
    tx_data  = 8'hC3;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    wait_strobes(7, "data_wait");
    check("gate_active_pre", gate_p | gate_n, 1);
    check("busy_pre", busy, 1);
    #2 nrst = 1'b0;
    #1;
    check("async_gates", {gate_p, gate_n}, 0);
    check("async_busy", busy, 0);
    check("async_phase", phase, 0);
    check("async_ready", tx_ready, 0);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    check("post_rst_step1", phase, 32'h1000_0000);
    @(negedge clk);
    check("post_rst_step2", phase, 32'h2000_0000);
    check("post_rst_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/swipt_bpsk_tx.md
SWIPT_BPSK_TX -- requirements
Module: swipt_bpsk_tx

Interface
REQ-001 SHALL have parameter PHASE_BITS, default 32, NCO accumulator width.
REQ-002 SHALL have parameter INITIAL_PHASE_STEP, default 32'h1000_0000, reset value of phase step.
REQ-003 SHALL have parameter CYCLES_PER_BIT, default 4, carrier cycles per symbol (range 1-255).
REQ-004 SHALL have parameter PREAMBLE_LEN, default 4, preamble symbols per frame (range 1-15).
REQ-005 SHALL have parameter DEAD_CYCLES, default 1, clocks both gates low around each edge (range 0-15).
REQ-006 SHALL have port clk  input  1  sole clock, rising edge.
REQ-007 SHALL have port nrst  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port swiptAlive  input  1  link enable; low aborts activity.
REQ-009 SHALL have port load_freq  input  1  load phase step from freq.
REQ-010 SHALL have port freq  input  PHASE_BITS-1  new phase step, zero-extended by one MSB.
REQ-011 SHALL have port tx_data  input  8  byte to send, MSB first.
REQ-012 SHALL have port tx_valid  input  1  tx_data valid.
REQ-013 SHALL have port tx_ready  output  1  byte accepted when tx_valid && tx_ready.
REQ-014 SHALL have port phase  output  PHASE_BITS  accumulator value.
REQ-015 SHALL have port gate_p / gate_n  output  1 each  complementary BPSK drive, registered.
REQ-016 SHALL have port busy  output  1  high in any state except IDLE.
REQ-017 SHALL have port bit_strobe  output  1  one-clock pulse at each symbol start in a frame.
REQ-018 SHALL have port frame_done  output  1  one-clock pulse after last data symbol with no follow-on byte.

Function
REQ-019 Accumulator SHALL add the phase step every clock while swiptAlive is high; it SHALL hold while swiptAlive is low.
REQ-020 wrap SHALL be the carry-out of that addition; wrap marks a carrier-cycle boundary.
REQ-021 load_freq SHALL load {1'b0, freq} into the step, taking effect on the next addition; load_freq SHALL work regardless of swiptAlive.
REQ-022 FSM SHALL have states IDLE, SYNC, PREAMBLE and DATA.
REQ-023 IDLE: tx_ready=1; a handshake SHALL capture tx_data into the shift register and go to SYNC.
REQ-024 SYNC: on wrap go to PREAMBLE, symbol 0, carrier counter 0, pulse bit_strobe.
REQ-025 A symbol SHALL last CYCLES_PER_BIT wraps; symbol changes SHALL occur only on wrap.
REQ-026 Preamble symbols SHALL alternate 1,0,1,... starting with 1; after PREAMBLE_LEN symbols go to DATA.
REQ-027 DATA SHALL send 8 symbols, shift register MSB first.
REQ-028 tx_ready SHALL also be 1 during the last DATA symbol while the holding register is empty; a byte accepted then SHALL follow directly with no preamble or SYNC.
REQ-029 After the last DATA symbol with no held byte, the FSM SHALL go to IDLE at that wrap and pulse frame_done.
REQ-030 Raw carrier SHALL be phase[MSB] XOR current symbol; the symbol is 0 in IDLE and SYNC.
REQ-031 Each raw-carrier toggle SHALL load the dead-time counter with DEAD_CYCLES.
REQ-032 While the dead-time counter is nonzero, both gates SHALL be 0.
REQ-033 Otherwise gate_p SHALL equal raw and gate_n SHALL equal !raw, registered, so gate_p and gate_n are never both 1.
REQ-034 Output latency SHALL be raw to gates 1 clock plus dead time.
REQ-035 swiptAlive low SHALL, on the next clock, drive the FSM to IDLE, discard the shift and holding registers, force both gates 0 and clear the dead-time counter.
REQ-036 tx_ready SHALL be 0 while swiptAlive is low.
REQ-037 Simultaneous load_freq and wrap SHALL let the wrap act with the old step.
REQ-038 A handshake in IDLE coinciding with swiptAlive falling SHALL be ignored.
REQ-039 tx_valid without tx_ready SHALL change no state.

Reset
REQ-040 nrst low SHALL asynchronously set: accumulator 0, step INITIAL_PHASE_STEP, FSM IDLE, counters 0, shift and holding registers empty.
REQ-041 nrst low SHALL asynchronously set outputs: gate_p 0, gate_n 0, busy 0, bit_strobe 0, frame_done 0, tx_ready 0; tx_ready rises after the first clock with nrst and swiptAlive high.
REQ-042 Reset release SHALL be synchronized to clk by the integrator; no internal synchronizer.

Verification
REQ-043 Default params, swiptAlive=1, no data -> phase increments 0x1000_0000 per clock; gate_p is high 7 clocks per 16-clock period, gate_n likewise, with 1-clock gaps between them.
REQ-044 Send 8'hA5 from IDLE -> bit_strobe at SYNC exit; symbols 1,0,1,0 then 1,0,1,0,0,1,0,1; each symbol 64 clocks; gate_p inverted vs unmodulated on 1-symbols; frame_done one clock at end; total 768 clocks after SYNC.
REQ-045 Second byte 8'h3C presented during the last symbol of the first -> accepted there; no preamble, DATA continues at the next wrap; a single frame_done after 8'h3C.
REQ-046 swiptAlive dropped mid-preamble -> next clock: IDLE, gates 0, phase frozen; re-enable -> tx_ready=1, fresh frame needed.
REQ-047 load_freq with freq=0x0800_0000 on a wrap clock -> that wrap uses the old step; carrier period becomes 32 clocks; symbol 128 clocks.
REQ-048 nrst asserted mid-DATA asynchronously -> gates 0 and busy 0 before the next clock edge; phase=0 and step=0x1000_0000 after release.
